// File: rtl/rsc_term_encoder.sv
`default_nettype none
// ============================================================================
// rsc_term_encoder : recursive systematic convolutional encoder, trellis-terminated
// Rev 1.0
// ============================================================================
module rsc_term_encoder #(
  parameter int           MEM   = 3,
  parameter logic [MEM:0] G_FB  = 4'b1101,
  parameter logic [MEM:0] G_FF  = 4'b1011,
  parameter int           LEN_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] blk_len,
  input  logic             din_valid,
  input  logic             din,
  output logic             din_ready,
  output logic             dout_valid,
  output logic             sys_out,
  output logic             par_out,
  output logic             tail_flag,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] c_len_one   = LEN_W'(1);
  localparam logic [2:0]       c_tail_last = 3'(MEM - 1);

  state_t           state_q, state_d;
  logic [MEM:1]     s_q, s_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [2:0]       tcnt_q, tcnt_d;
  logic             dv_q, dv_d, sys_q, sys_d, par_q, par_d, tail_q, tail_d, done_q, done_d;
  logic             fb, x, a, z;

  // In TAIL the input is the feedback itself, which drives a to zero and flushes s.
  always_comb begin
    fb = ^(G_FB[MEM:1] & s_q);
    x  = (state_q == ST_TAIL) ? fb : din;
    a  = x ^ fb;
    z  = (G_FF[0] & a) ^ (^(G_FF[MEM:1] & s_q));
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    dv_d    = 1'b0;
    sys_d   = 1'b0;
    par_d   = 1'b0;
    tail_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = blk_len;
          s_d     = '0;
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = (blk_len == '0) ? ST_TAIL : ST_DATA;
        end
      end
      ST_DATA: begin
        if (din_valid) begin
          s_d   = {s_q[MEM-1:1], a};
          dv_d  = 1'b1;
          sys_d = din;
          par_d = z;
          cnt_d = cnt_q + c_len_one;
          if (cnt_q + c_len_one == len_q) begin
            state_d = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        s_d    = {s_q[MEM-1:1], a};
        dv_d   = 1'b1;
        sys_d  = fb;
        par_d  = z;
        tail_d = 1'b1;
        tcnt_d = tcnt_q + 3'd1;
        if (tcnt_q == c_tail_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      dv_q    <= 1'b0;
      sys_q   <= 1'b0;
      par_q   <= 1'b0;
      tail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      dv_q    <= dv_d;
      sys_q   <= sys_d;
      par_q   <= par_d;
      tail_q  <= tail_d;
      done_q  <= done_d;
    end
  end

  // Outputs are held low for the whole time rst is asserted, not only after the edge.
  assign din_ready  = (state_q == ST_DATA) & ~rst;
  assign busy       = (state_q != ST_IDLE) & ~rst;
  assign dout_valid = dv_q & ~rst;
  assign sys_out    = sys_q & ~rst;
  assign par_out    = par_q & ~rst;
  assign tail_flag  = tail_q & ~rst;
  assign done       = done_q & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_rsc_term_encoder.sv
`default_nettype none
// Self-checking bench for rsc_term_encoder: block-level reference model plus scoreboard.
module tb_rsc_term_encoder;
  localparam int         MEM   = 3;
  localparam int         LEN_W = 13;
  localparam logic [3:0] GFB   = 4'b1101;
  localparam logic [3:0] GFF   = 4'b1011;

  logic clk, rst, start, din_valid, din;
  logic [LEN_W-1:0] blk_len;
  logic din_ready, dout_valid, sys_out, par_out, tail_flag, done, busy;

  rsc_term_encoder #(.MEM(MEM), .G_FB(GFB), .G_FF(GFF), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .dout_valid(dout_valid), .sys_out(sys_out), .par_out(par_out),
    .tail_flag(tail_flag), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic sys;
    logic par;
    logic tail;
    logic done;
  } out_t;

  out_t exp_q[$];
  out_t mdl_q[$];
  logic blk_bits[$];
  int   blk_gaps[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic prev_xfer = 1'b0;
  logic last_valid = 1'b0;
  logic last_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Whole-block reference: run the recursion over data bits then MEM flush bits.
  function automatic void model(input int len);
    int s[1:6];
    mdl_q.delete();
    for (int k = 1; k <= 6; k++) s[k] = 0;
    for (int i = 0; i < len + MEM; i++) begin
      int fb, x, a, z;
      out_t o;
      fb = 0;
      for (int k = 1; k <= MEM; k++) fb ^= GFB[k] ? s[k] : 0;
      x = (i < len) ? (blk_bits[i] ? 1 : 0) : fb;
      a = x ^ fb;
      z = GFF[0] ? a : 0;
      for (int k = 1; k <= MEM; k++) z ^= GFF[k] ? s[k] : 0;
      o.sys  = (x != 0);
      o.par  = (z != 0);
      o.tail = (i >= len);
      o.done = (i == len + MEM - 1);
      mdl_q.push_back(o);
      for (int k = MEM; k >= 2; k--) s[k] = s[k-1];
      s[1] = a;
    end
  endfunction

  always @(posedge clk) prev_xfer <= din_valid & din_ready;

  always @(negedge clk) begin
    out_t e;
    if (rst) begin
      chk("rst_outputs_low", {din_ready, dout_valid, sys_out, par_out, tail_flag, done, busy}, 0);
      last_valid <= 1'b0;
    end else begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sys_out", sys_out, e.sys);
          chk("par_out", par_out, e.par);
          chk("tail_flag", tail_flag, e.tail);
          chk("done", done, e.done);
          if (!e.tail) chk("data_latency", prev_xfer, 1);
          last_done <= e.done;
        end
      end else begin
        chk("done_without_output", done, 0);
        if (prev_xfer) chk("missing_data_output", 0, 1);
        if (exp_q.size() > 0 && exp_q[0].tail && last_valid && !last_done)
          chk("tail_gap", 0, 1);
      end
      last_valid <= dout_valid;
    end
  end

  task automatic load_expected(input int len);
    model(len);
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
  endtask

  // Returns at the negedge of the done cycle so a follow-on start lands in that cycle.
  task automatic run_block(input int len, input bit pulse);
    bit got;
    load_expected(len);
    start   = 1'b1;
    blk_len = LEN_W'(len);
    @(posedge clk); #1;
    start   = 1'b0;
    blk_len = LEN_W'($urandom);
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < blk_gaps[i]; g++) begin
        din_valid = 1'b0;
        din       = ($urandom_range(0, 1) == 1);
        start     = pulse && ($urandom_range(0, 2) == 0);
        @(negedge clk);
        chk("din_ready_gap", din_ready, 1);
        @(posedge clk); #1;
        start = 1'b0;
      end
      din_valid = 1'b1;
      din       = blk_bits[i];
      start     = pulse && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      chk("din_ready_data", din_ready, 1);
      chk("busy_data", busy, 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    din_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < MEM + 4; c++) begin
      @(negedge clk);
      chk("din_ready_low", din_ready, 0);
      if (done) begin
        chk("busy_in_done_cycle", busy, 0);
        got = 1'b1;
        break;
      end
      chk("busy_tail", busy, 1);
      if (pulse && c == 0) begin
        start   = 1'b1;
        blk_len = LEN_W'($urandom_range(1, 5));
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk("done_seen", got, 1);
  endtask

  task automatic set_block(input int len, input bit gapped);
    blk_bits.delete();
    blk_gaps.delete();
    for (int i = 0; i < len; i++) begin
      blk_bits.push_back($urandom_range(0, 1) == 1);
      blk_gaps.push_back((gapped && $urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0);
    end
  endtask

  task automatic reset_mid_block();
    set_block(10, 1'b0);
    load_expected(10);
    start   = 1'b1;
    blk_len = LEN_W'(10);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1;
      din       = blk_bits[i];
      @(posedge clk); #1;
    end
    rst       = 1'b1;
    din_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outputs", {din_ready, dout_valid, sys_out, par_out, tail_flag, done, busy}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0] sv, pv, dv;
    logic [3:0] s4, p4, t4;
    rst = 1'b1; start = 1'b0; blk_len = '0; din_valid = 1'b0; din = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_idle", {busy, din_ready, dout_valid, done}, 0);

    // Hand-derived sequences pin the model before it is trusted.
    blk_bits.delete();
    blk_bits.push_back(1'b1); blk_bits.push_back(1'b0);
    blk_bits.push_back(1'b1); blk_bits.push_back(1'b1);
    model(4);
    for (int i = 0; i < 7; i++) begin
      sv[i] = mdl_q[i].sys; pv[i] = mdl_q[i].par; dv[i] = mdl_q[i].done;
    end
    chk("model_len4_sys", sv, 7'b0001101);
    chk("model_len4_par", pv, 7'b0001011);
    chk("model_len4_done", dv, 7'b1000000);
    blk_bits.delete();
    blk_bits.push_back(1'b1);
    model(1);
    for (int i = 0; i < 4; i++) begin
      s4[i] = mdl_q[i].sys; p4[i] = mdl_q[i].par; t4[i] = mdl_q[i].tail;
    end
    chk("model_len1_sys", s4, 4'b1101);
    chk("model_len1_par", p4, 4'b1011);
    chk("model_len1_tail", t4, 4'b1110);

    // Back-to-back 1011 then single-bit block started in the done cycle.
    blk_bits.delete(); blk_gaps.delete();
    blk_bits.push_back(1'b1); blk_bits.push_back(1'b0);
    blk_bits.push_back(1'b1); blk_bits.push_back(1'b1);
    repeat (4) blk_gaps.push_back(0);
    run_block(4, 1'b0);
    blk_bits.delete(); blk_gaps.delete();
    blk_bits.push_back(1'b1); blk_gaps.push_back(0);
    run_block(1, 1'b0);
    @(posedge clk); #1;

    // din_valid 1,0,0,1,1,0,1 with start pulses during DATA and TAIL.
    blk_bits.delete(); blk_gaps.delete();
    blk_bits.push_back(1'b1); blk_bits.push_back(1'b0);
    blk_bits.push_back(1'b1); blk_bits.push_back(1'b1);
    blk_gaps.push_back(0); blk_gaps.push_back(2);
    blk_gaps.push_back(0); blk_gaps.push_back(1);
    run_block(4, 1'b1);
    repeat (2) @(posedge clk); #1;

    blk_bits.delete(); blk_gaps.delete();
    run_block(0, 1'b1);
    @(posedge clk); #1;

    reset_mid_block();
    set_block(5, 1'b0);
    run_block(5, 1'b0);
    @(posedge clk); #1;

    for (int b = 0; b < 25; b++) begin
      int len;
      len = $urandom_range(0, 24);
      set_block(len, $urandom_range(0, 1) == 1);
      run_block(len, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (6) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rsc_term_encoder.md
RSC_TERM_ENCODER -- requirements
Module: rsc_term_encoder

Interface
REQ-001 SHALL have parameter MEM, default 3, meaning the number of encoder memory stages (legal 2..6).
REQ-002 SHALL have parameter G_FB, default 4'b1101, meaning the feedback polynomial; bit k is the coefficient of D^k and bit 0 SHALL be 1.
REQ-003 SHALL have parameter G_FF, default 4'b1011, meaning the feedforward polynomial; bit k is the coefficient of D^k.
REQ-004 SHALL have parameter LEN_W, default 13, meaning the width of blk_len (max block 2^LEN_W-1).
REQ-005 clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  single-cycle request to begin a block; sampled only in IDLE.
REQ-008 blk_len  input  LEN_W  number of information bits in the block; latched on an accepted start.
REQ-009 din_valid  input  1  din carries a valid information bit.
REQ-010 din  input  1  information bit.
REQ-011 din_ready  output  1  encoder accepts din this cycle; high only in DATA.
REQ-012 dout_valid  output  1  sys_out and par_out valid this cycle.
REQ-013 sys_out  output  1  systematic bit (data or tail).
REQ-014 par_out  output  1  parity bit.
REQ-015 tail_flag  output  1  current output is a termination bit.
REQ-016 done  output  1  one-cycle pulse coincident with the last tail output.
REQ-017 busy  output  1  high in DATA and TAIL.

Function
REQ-018 SHALL hold shift state s[1..MEM], where s[k] is the feedback value a delayed k accepted cycles.
REQ-019 SHALL compute fb = XOR over k=1..MEM of (G_FB[k] & s[k]), a = x ^ fb, and z = (G_FF[0] & a) ^ XOR over k=1..MEM of (G_FF[k] & s[k]).
REQ-020 SHALL, on each shift, move s[k] to s[k+1] and load a into s[1].
REQ-021 SHALL implement FSM states IDLE, DATA and TAIL only.
REQ-022 SHALL, in IDLE on start=1, latch blk_len, clear s and the counters, and go to DATA (go to TAIL if blk_len=0).
REQ-023 SHALL shift in DATA only on din_valid & din_ready, with x = din; dout_valid is low in cycles without a transfer.
REQ-024 SHALL register outputs with one-cycle latency: transfer in cycle n gives dout_valid=1, sys_out=din, par_out=z, tail_flag=0 in cycle n+1.
REQ-025 SHALL move to TAIL in the cycle after the blk_len-th transfer; din_ready SHALL be low from that cycle on.
REQ-026 SHALL spend exactly MEM cycles in TAIL, each with x = fb (so a=0), shifting unconditionally; each tail output is dout_valid=1, sys_out=fb, par_out=z, tail_flag=1, one cycle later.
REQ-027 SHALL assert done with the MEM-th tail output, return to IDLE, and leave s all-zero.
REQ-028 SHALL ignore start outside IDLE; start in the same cycle done is high SHALL be accepted (FSM is already in IDLE).
REQ-029 SHALL produce exactly blk_len + MEM valid outputs per block, in order, with no output backpressure.

Reset
REQ-030 SHALL, while rst=1, force state IDLE, s=0, counters=0, and din_ready, dout_valid, sys_out, par_out, tail_flag, done and busy all to 0.
REQ-031 SHALL, on rst mid-block, abandon the block with no done pulse; the next start SHALL encode normally.

Verification
REQ-032 Reset: hold rst=1 for 2 cycles during DATA -> all outputs 0 the next cycle, state IDLE, no done.
REQ-033 Defaults, blk_len=4, din=1,0,1,1 back-to-back -> sys 1,0,1,1 and par 1,1,0,1; then tail sys 0,0,0, par 0,0,0; done on the 7th output.
REQ-034 Defaults, blk_len=1, din=1 -> data output sys 1, par 1; tail sys 0,1,1 and par 1,0,1 with tail_flag=1; done on the last tail output.
REQ-035 Gapped din_valid (1,0,0,1,1,0,1), blk_len=4 -> same values as REQ-033, with dout_valid gaps matching the input gaps delayed 1 cycle.
REQ-036 start pulsed during DATA and during TAIL -> ignored; start in the done cycle -> new block begins with s=0.
REQ-037 blk_len=0 -> exactly 3 tail outputs, all 0, done on the third; din_ready never high.
